fifo_write_arbiter: RTL

Round-robin write-side arbiter that shares one byte-wide FIFO between `N_REQ` producers. It grants FIFO write ownership to one requester at a time, for a burst of up to `MAX_BURST` accepted beats, and muxes that requester's data onto the FIFO write port. It never writes while the FIFO reports full. It sits directly in front of the FIFO's `we`/`data_in`/`full` pins.

---
 rtl/fifo_write_arbiter_pkg.sv | 38 +++
 rtl/fifo_write_arbiter_rr_priority_pick.sv | 30 +++
 rtl/fifo_write_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_write_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Largest supported requester count, and the owner index width it needs.
    localparam int MAX_REQ = 8;
    localparam int PICK_W  = $clog2(MAX_REQ);

    // Index of the first set request after `last`, searching upward and
    // wrapping modulo n. Returns 0 when nothing is requested; callers gate
    // the result with their own valid flag.
    function automatic logic [PICK_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PICK_W-1:0]  last,
        input int                 n
    );
        logic [PICK_W-1:0] pick;
        logic              found;
        int                idx;
        pick  = '0;
        found = 1'b0;
        for (int off = 1; off <= MAX_REQ; off++) begin
            if (off <= n) begin
                idx = (int'(last) + off) % n;
                if (!found && req[idx[PICK_W-1:0]]) begin
                    pick  = idx[PICK_W-1:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_priority_pick.sv
// Combinational rotate-and-priority-encode: next requester after `last`.
module rr_priority_pick
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int OWNER_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] last,
    output logic [N_REQ-1:0]   winner,
    output logic [OWNER_W-1:0] winner_id,
    output logic               valid
);

    logic [MAX_REQ-1:0] req_pad;
    logic [PICK_W-1:0]  last_pad;
    logic [PICK_W-1:0]  pick;

    // Widen to the package's fixed search width, pick, then narrow back.
    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        req_pad   = MAX_REQ'(req);
        last_pad  = PICK_W'(last);
        pick      = rr_pick(req_pad, last_pad, N_REQ);
        valid     = |req;
        winner_id = OWNER_W'(pick);
        winner    = valid ? (N_REQ'(1) << winner_id) : '0;
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin write-side arbiter sharing one FIFO write port between
// N_REQ producers, granting bursts of up to MAX_BURST accepted beats.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          grant,
    output logic [$clog2(N_REQ)-1:0]  owner_id,
    output logic                      busy,
    input  logic                      fifo_full,
    output logic                      fifo_we,
    output logic [DATA_W-1:0]         fifo_data
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    state_t            state;
    logic [CNT_W-1:0]  beat_cnt;
    logic              owner_req;
    logic [N_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]   pick_id;
    logic              pick_valid;

    rr_priority_pick #(
        .N_REQ   (N_REQ),
        .OWNER_W (ID_W)
    ) u_pick (
        .req       (req),
        .last      (owner_id),
        .winner    (pick_onehot),
        .winner_id (pick_id),
        .valid     (pick_valid)
    );

    // Write port: only the owner writes, only in GRANT, never into a full FIFO.
    always_comb begin
        owner_req = req[owner_id];
        fifo_we   = (state == GRANT) && owner_req && !fifo_full;
        ack       = grant & {N_REQ{fifo_we}};
        fifo_data = req_data[int'(owner_id)*DATA_W +: DATA_W];
    end

    // Grant FSM with beat counter; owner_id doubles as the round-robin pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!reset) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            beat_cnt <= '0;
            owner_id <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid && !fifo_full) begin
                        state    <= GRANT;
                        grant    <= pick_onehot;
                        owner_id <= pick_id;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || (fifo_we && beat_cnt == LAST_BEAT)) begin
                        state    <= IDLE;
                        grant    <= '0;
                        busy     <= 1'b0;
                        beat_cnt <= '0;
                    end else if (fifo_we) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
